// File: rtl/glitch_filter_ctrl.sv
// Multi-channel glitch filter: per-channel run-length qualification of din,
// with accepted level changes queued and granted round-robin to one event port.
module glitch_filter_ctrl #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CW      = 4,
  parameter int unsigned THR_RST = 4,
  parameter int unsigned CHW     = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] din,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_thr,
  input  logic           cfg_en,
  output logic [NCH-1:0] dout,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [CHW-1:0] evt_ch,
  output logic           evt_level,
  output logic           evt_ovf
);

  // Per-channel configuration and filter state
  logic [CW-1:0]  thr_q [NCH];
  logic [CW-1:0]  cnt_q [NCH];
  logic [NCH-1:0] en_q;
  logic [NCH-1:0] smp_q;

  // Event queue state: one pending slot per channel
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] plev_q;
  logic [NCH-1:0] ovf_q;
  logic [CHW-1:0] ptr_q;

  // Next-state signals
  logic [CW-1:0]  cnt_d [NCH];
  logic [CW-1:0]  thr_eff;
  logic [NCH-1:0] dout_d;
  logic [NCH-1:0] chg;
  logic [NCH-1:0] pend_d;
  logic [NCH-1:0] plev_d;
  logic [NCH-1:0] ovf_d;
  logic [CHW-1:0] ptr_d;
  logic [CHW-1:0] gnt_ch;
  logic [CHW-1:0] idx;
  logic           gnt_vld;
  logic           load;
  logic           cfg_hit;
  logic           evt_valid_d;
  logic [CHW-1:0] evt_ch_d;
  logic           evt_level_d;
  logic           evt_ovf_d;

  assign cfg_hit = cfg_we && (32'(cfg_ch) < NCH);

  // Configuration registers; a write lands at this edge and is used from the next cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) thr_q[i] <= CW'(THR_RST);
      en_q <= '1;
    end else if (cfg_hit) begin
      thr_q[cfg_ch] <= cfg_thr;
      en_q[cfg_ch]  <= cfg_en;
    end
  end

  // Run-length counting: a level must hold thr samples before it reaches dout
  always_comb begin
    dout_d  = dout;
    chg     = '0;
    thr_eff = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      thr_eff  = (thr_q[i] == '0) ? CW'(1) : thr_q[i];
      if (en_q[i]) begin
        if (din[i] != smp_q[i])       cnt_d[i] = CW'(1);
        else if (cnt_q[i] >= thr_eff) cnt_d[i] = thr_eff;
        else                          cnt_d[i] = cnt_q[i] + CW'(1);
        if ((cnt_d[i] >= thr_eff) && (din[i] != dout[i])) begin
          dout_d[i] = din[i];
          chg[i]    = 1'b1;
        end
      end
    end
  end

  // Filter state registers; sampling continues even while a channel is disabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      smp_q <= '0;
      dout  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      smp_q <= din;
      dout  <= dout_d;
    end
  end

  // Round-robin search: first pending channel at or above the pointer, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CHW'((32'(ptr_q) + 32'(k)) % NCH);
      if (pend_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx;
      end
    end
  end

  // Event bookkeeping: grant uses pre-edge pending, then this edge's changes are merged
  always_comb begin
    load        = ~evt_valid | evt_ready;
    pend_d      = pend_q;
    plev_d      = plev_q;
    ovf_d       = ovf_q;
    ptr_d       = ptr_q;
    evt_valid_d = evt_valid;
    evt_ch_d    = evt_ch;
    evt_level_d = evt_level;
    evt_ovf_d   = evt_ovf;
    if (load) begin
      evt_valid_d = gnt_vld;
      if (gnt_vld) begin
        evt_ch_d       = gnt_ch;
        evt_level_d    = plev_q[gnt_ch];
        evt_ovf_d      = ovf_q[gnt_ch];
        pend_d[gnt_ch] = 1'b0;
        ovf_d[gnt_ch]  = 1'b0;
        ptr_d          = CHW'((32'(gnt_ch) + 32'd1) % NCH);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (chg[i]) begin
        if (pend_d[i]) ovf_d[i] = 1'b1;
        pend_d[i] = 1'b1;
        plev_d[i] = dout_d[i];
      end
    end
  end

  // Event queue and output port registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q    <= '0;
      plev_q    <= '0;
      ovf_q     <= '0;
      ptr_q     <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_level <= 1'b0;
      evt_ovf   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      plev_q    <= plev_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
      evt_valid <= evt_valid_d;
      evt_ch    <= evt_ch_d;
      evt_level <= evt_level_d;
      evt_ovf   <= evt_ovf_d;
    end
  end

endmodule

// File: tb/tb_glitch_filter_ctrl.sv
// Randomized scoreboard bench for glitch_filter_ctrl against a behavioural model.
module tb_glitch_filter_ctrl;

  localparam int unsigned NCH     = 4;
  localparam int unsigned CW      = 4;
  localparam int unsigned THR_RST = 4;
  localparam int unsigned CHW     = 2;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           lvl;
    logic           ovf;
  } evt_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NCH-1:0] din;
  logic           cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_thr;
  logic           cfg_en;
  logic [NCH-1:0] dout;
  logic           evt_valid;
  logic           evt_ready;
  logic [CHW-1:0] evt_ch;
  logic           evt_level;
  logic           evt_ovf;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int             m_run [NCH];
  logic [CW-1:0]  m_thr [NCH];
  logic [NCH-1:0] m_en, m_prev, m_dout, m_pend, m_plev, m_ovf;
  int             m_ptr;
  logic           m_valid;
  evt_t           q [$];

  // Monitor history for stall-stability checking
  logic pv, pr;
  evt_t pe;

  glitch_filter_ctrl #(.NCH(NCH), .CW(CW), .THR_RST(THR_RST), .CHW(CHW)) dut (
    .clk(clk), .rstn(rstn), .din(din),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_thr(cfg_thr), .cfg_en(cfg_en),
    .dout(dout), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_level(evt_level), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0;
      m_thr[i] = CW'(THR_RST);
    end
    m_en = '1; m_prev = '0; m_dout = '0;
    m_pend = '0; m_plev = '0; m_ovf = '0;
    m_ptr = 0; m_valid = 1'b0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs the bench is driving
  function automatic void model_step();
    logic [NCH-1:0] chg = '0;
    int te, g, c;
    evt_t e;
    for (int i = 0; i < NCH; i++) begin
      te = (m_thr[i] == 0) ? 1 : int'(m_thr[i]);
      if (!m_en[i]) m_run[i] = 0;
      else begin
        m_run[i] = (din[i] != m_prev[i]) ? 1 : ((m_run[i] < 1000) ? m_run[i] + 1 : 1000);
        if (m_run[i] >= te && din[i] != m_dout[i]) begin
          m_dout[i] = din[i];
          chg[i] = 1'b1;
        end
      end
      m_prev[i] = din[i];
    end
    if (!m_valid || evt_ready) begin
      g = -1;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (g < 0 && m_pend[c]) g = c;
      end
      m_valid = (g >= 0);
      if (g >= 0) begin
        e.ch = CHW'(g); e.lvl = m_plev[g]; e.ovf = m_ovf[g];
        q.push_back(e);
        m_pend[g] = 1'b0; m_ovf[g] = 1'b0;
        m_ptr = (g + 1) % NCH;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (chg[i]) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        m_pend[i] = 1'b1;
        m_plev[i] = m_dout[i];
      end
    end
    if (cfg_we && int'(cfg_ch) < NCH) begin
      m_thr[cfg_ch] = cfg_thr;
      m_en[cfg_ch]  = cfg_en;
    end
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_dout", 32'(dout), 32'(0));
    chk("rst_evt_valid", 32'(evt_valid), 32'(0));
    chk("rst_evt_ch", 32'(evt_ch), 32'(0));
    chk("rst_evt_level", 32'(evt_level), 32'(0));
    chk("rst_evt_ovf", 32'(evt_ovf), 32'(0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    model_step();
  endtask

  // One cycle: check outputs against the model, drive new random inputs, advance model
  task automatic cycle(input int flip_div, input int ready_pct, input int cfg_div, input bit sync);
    @(negedge clk);
    chk("dout", 32'(dout), 32'(m_dout));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (flip_div > 0) begin
      if (sync) begin
        if ($urandom_range(flip_div - 1) == 0) din = ~din;
      end else begin
        for (int i = 0; i < NCH; i++)
          if ($urandom_range(flip_div - 1) == 0) din[i] = ~din[i];
      end
    end
    cfg_we  = (cfg_div > 0) && ($urandom_range(cfg_div - 1) == 0);
    cfg_ch  = CHW'($urandom_range(NCH - 1));
    cfg_thr = CW'($urandom_range(15));
    cfg_en  = ($urandom_range(4) != 0);
    evt_ready = ($urandom_range(99) < ready_pct);
    @(posedge clk);
    model_step();
  endtask

  // Asynchronous reset in the middle of traffic
  task automatic mid_reset();
    @(negedge clk);
    chk("dout", 32'(dout), 32'(m_dout));
    #2;
    rstn = 1'b0;
    cfg_we = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    q.delete();
    release_reset();
  endtask

  // Scoreboard monitor: pops the expected event on every handshake
  initial begin
    pv = 1'b0; pr = 1'b0; pe = '0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) pv = 1'b0;
      else begin
        if (pv && !pr)
          chk("stall_hold", 32'({evt_valid, evt_ch, evt_level, evt_ovf}), 32'({1'b1, pe}));
        if (evt_valid && evt_ready) begin
          if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL evt_extra: got ch=%0d lvl=%0d ovf=%0d required none at %0t",
                     evt_ch, evt_level, evt_ovf, $time);
          end else begin
            chk("evt", 32'({evt_ch, evt_level, evt_ovf}), 32'(q.pop_front()));
          end
        end
        pv = evt_valid; pr = evt_ready;
        pe = '{ch: evt_ch, lvl: evt_level, ovf: evt_ovf};
      end
    end
  end

  initial begin
    int fd [6] = '{8, 3, 40, 10, 5, 25};
    int rp [6] = '{80, 30, 70, 10, 50, 90};
    int cd [6] = '{30, 20, 50, 25, 6, 40};
    bit sy [6] = '{0, 0, 0, 1, 0, 1};
    rstn = 1'b0; din = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_thr = '0; cfg_en = 1'b0;
    evt_ready = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset_outputs();
    release_reset();
    for (int p = 0; p < 6; p++) begin
      repeat (400) cycle(fd[p], rp[p], cd[p], sy[p]);
      if (p == 1 || p == 3) mid_reset();
    end
    repeat (60) cycle(0, 100, 0, 1'b0);
    @(negedge clk);
    chk("drain_queue", 32'(q.size()), 32'(0));
    chk("drain_valid", 32'(evt_valid), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
